mem_access_cycle: RTL and testbench
===================================

MEM_ACCESS_CYCLE -- requirements
Module: mem_access_cycle

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 16: cycles in WAIT without dmem_ack before the access aborts.
REQ-002 SHALL have clk  in  1  clock; all state is updated on the rising edge.
REQ-003 SHALL have rst  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have these EX/MEM inputs:
- RegWriteM  in  1  register write enable.
- MemWriteM  in  1  store.
- ResultSrcM  in  2  writeback select (00 ALU, 01 load, 10 PC+4).
- Funct3M  in  3  access width/sign.
- RD_M  in  5  destination register.
- ALU_ResultM  in  32  effective address / ALU result.
- WriteDataM  in  32  store data.
- PCPlus4M  in  32  return address.
REQ-005 SHALL have these data-memory ports:
- dmem_req  out  1  request.
- dmem_we  out  1  write.
- dmem_addr  out  32  word address.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-aligned store data.
- dmem_ack  in  1  completion.
- dmem_rdata  in  32  read word, valid with dmem_ack.
REQ-006 SHALL have these MEM/WB outputs:
- RegWriteW  out  1  register write enable.
- ResultSrcW  out  2  writeback select.
- RD_W  out  5  destination register.
- ALU_ResultW  out  32  ALU result.
- ReadDataW  out  32  extended load data.
- PCPlus4W  out  32  return address.
REQ-007 SHALL have these status outputs:
- StallM  out  1  hold EX/MEM and all upstream stages.
- MisalignM  out  1  one-cycle misaligned-access flag.
- BusErrM  out  1  one-cycle timeout flag.

Function
REQ-008 An access SHALL be MemWriteM=1 (store) or ResultSrcM=01 (load); any other input SHALL pass straight to MEM/WB with no dmem activity.
REQ-009 The FSM SHALL have states IDLE and WAIT. IDLE with an aligned access SHALL drive dmem_req=1 combinationally in the same cycle. On dmem_ack the access completes; without dmem_ack the FSM goes to WAIT.
REQ-010 WAIT SHALL hold dmem_req=1 and all dmem outputs stable until dmem_ack. On dmem_ack the FSM goes to IDLE and the access completes.
REQ-011 StallM SHALL be 1 exactly when an access is outstanding in the current cycle without dmem_ack and without timeout; upstream SHALL hold the EX/MEM inputs stable while StallM=1.
REQ-012 dmem_addr SHALL be {ALU_ResultM[31:2],2'b00}, and dmem_we SHALL equal MemWriteM.
REQ-013 Stores SHALL drive dmem_be and dmem_wdata as follows:
- SB: be=0001<<a[1:0], byte replicated to all four lanes.
- SH: be=0011<<{a[1],0}, halfword replicated to both halves.
- SW: be=1111, data unchanged.
REQ-014 Loads SHALL select the addressed lane of dmem_rdata and extend it to 32 bits: LB/LH sign-extend, LBU/LHU zero-extend, LW is the full word. Loads drive be=1111.
REQ-015 A halfword access with a[0]=1, or a word access with a[1:0]!=00, SHALL issue no request and assert MisalignM for 1 cycle. It SHALL not stall, and it SHALL set RegWriteW=0 for that instruction.
REQ-016 In WAIT, a cycle counter SHALL increment every cycle. When it reaches MAX_WAIT-1 without dmem_ack:
- dmem_req drops in that cycle;
- BusErrM pulses for 1 cycle;
- StallM=0;
- the instruction retires with RegWriteW=0;
- the FSM goes to IDLE.
The counter SHALL clear on entry to WAIT.
REQ-017 dmem_ack and timeout in the same cycle SHALL be treated as a successful completion.
REQ-018 The MEM/WB register SHALL load on every cycle with StallM=0. On every cycle with StallM=1 it SHALL load a bubble: RegWriteW=0, other fields don't-care.
REQ-019 Latency SHALL be 1 cycle from the EX/MEM inputs to the MEM/WB outputs when dmem_ack is 0-wait, and 1+N cycles when the memory takes N wait cycles.
REQ-020 dmem_ack while dmem_req=0 SHALL be ignored.

Reset
REQ-021 rst=0 SHALL force the FSM to IDLE and the counter to 0.
REQ-022 rst=0 SHALL clear all MEM/WB outputs to 0.
REQ-023 rst=0 SHALL force dmem_req, StallM, MisalignM and BusErrM to 0 immediately, including mid-WAIT; an aborted access is not replayed.

Structure
REQ-024 Shared package SHALL hold the funct3 load/store encodings, the ResultSrc encodings, and the FSM state enum.
REQ-025 One combinational sub-module lsu_lane_align SHALL provide the be/wdata generation, the load extraction/extension, and misalignment detection.

Verification
REQ-026 SW, a=0x100, data=0xDEADBEEF, 0-wait ack -> dmem_req=1, be=1111, addr=0x100, StallM=0, no BusErrM.
REQ-027 LB, a=0x203, rdata=0x80FF_1234 with ack after 3 wait cycles -> StallM=1 for 3 cycles, 3 bubbles, then ReadDataW=0xFFFFFF80, RegWriteW=1.
REQ-028 LHU, a=0x202, rdata=0x80FF_1234 -> ReadDataW=0x000080FF; SB, a=0x1, data=0xAB -> be=0010, wdata=0xABABABAB.
REQ-029 LW, a=0x102 -> MisalignM pulse, dmem_req=0 throughout, RegWriteW=0, StallM=0.
REQ-030 Load with no ack, MAX_WAIT=16 -> BusErrM pulse after 16 stall cycles, RegWriteW=0, FSM in IDLE; a following access proceeds normally.
REQ-031 rst pulsed low mid-WAIT -> dmem_req=0 and StallM=0 immediately, all outputs 0, next access starts from IDLE.

Source files
------------

// File: rtl/mem_access_cycle_pkg.sv
// Shared encodings for the MEM-stage data-memory access unit: funct3 widths,
// writeback selects and the access FSM state type.
package mem_access_cycle_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [1:0] RS_ALU  = 2'b00;
   localparam logic [1:0] RS_LOAD = 2'b01;
   localparam logic [1:0] RS_PC4  = 2'b10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   function automatic logic is_access(input logic mem_write, input logic [1:0] result_src);
      return mem_write | (result_src == RS_LOAD);
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for stores, lane extraction/extension for loads, and
// natural-alignment checking for halfword/word accesses.
module lsu_lane_align
   import mem_access_cycle_pkg::*;
(
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_lane,
   output logic [31:0] rdata_ext,
   output logic        misalign
);

   logic [31:0] rdata_sh;

   always_comb begin
      be         = '1;
      wdata_lane = wdata;
      misalign   = 1'b0;
      case (funct3[1:0])
         2'b00: begin
            if (is_store) begin
               be         = 4'b0001 << addr_lo;
               wdata_lane = {4{wdata[7:0]}};
            end
         end
         2'b01: begin
            misalign = addr_lo[0];
            if (is_store) begin
               be         = 4'b0011 << {addr_lo[1], 1'b0};
               wdata_lane = {2{wdata[15:0]}};
            end
         end
         2'b10:   misalign = (addr_lo != 2'b00);
         default: ;
      endcase
   end

   // Shifting the addressed lane down to bit 0 makes byte and halfword extraction uniform.
   assign rdata_sh = rdata >> {addr_lo, 3'b000};

   always_comb begin
      case (funct3)
         F3_B:    rdata_ext = {{24{rdata_sh[7]}}, rdata_sh[7:0]};
         F3_H:    rdata_ext = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
         F3_BU:   rdata_ext = {24'h0, rdata_sh[7:0]};
         F3_HU:   rdata_ext = {16'h0, rdata_sh[15:0]};
         default: rdata_ext = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_cycle.sv
// MEM stage: issues loads/stores to a handshaked data memory, stalls the
// pipeline while waiting, aborts on timeout and feeds the MEM/WB register.
module mem_access_cycle
   import mem_access_cycle_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        RegWriteM,
   input  logic        MemWriteM,
   input  logic [1:0]  ResultSrcM,
   input  logic [2:0]  Funct3M,
   input  logic [4:0]  RD_M,
   input  logic [31:0] ALU_ResultM,
   input  logic [31:0] WriteDataM,
   input  logic [31:0] PCPlus4M,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        RegWriteW,
   output logic [1:0]  ResultSrcW,
   output logic [4:0]  RD_W,
   output logic [31:0] ALU_ResultW,
   output logic [31:0] ReadDataW,
   output logic [31:0] PCPlus4W,
   output logic        StallM,
   output logic        MisalignM,
   output logic        BusErrM
);

   localparam int unsigned CNT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             access, misalign, in_idle, in_wait, timeout, req;
   logic [31:0]      rdata_ext;

   lsu_lane_align u_align (
      .is_store   (MemWriteM),
      .funct3     (Funct3M),
      .addr_lo    (ALU_ResultM[1:0]),
      .wdata      (WriteDataM),
      .rdata      (dmem_rdata),
      .be         (dmem_be),
      .wdata_lane (dmem_wdata),
      .rdata_ext  (rdata_ext),
      .misalign   (misalign)
   );

   assign access  = is_access(MemWriteM, ResultSrcM);
   assign in_idle = (state == ST_IDLE);
   assign in_wait = (state == ST_WAIT);

   // Status outputs are gated by rst so they fall the instant reset asserts, even mid-WAIT.
   // Ack on the final wait cycle wins over the timeout.
   assign timeout = rst & in_wait & (cnt == CNT_LAST) & ~dmem_ack;
   assign req     = rst & ((in_idle & access & ~misalign) | (in_wait & ~timeout));

   assign dmem_req  = req;
   assign dmem_we   = MemWriteM;
   assign dmem_addr = {ALU_ResultM[31:2], 2'b00};
   assign StallM    = req & ~dmem_ack;
   assign MisalignM = rst & in_idle & access & misalign;
   assign BusErrM   = timeout;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req && !dmem_ack) begin
                  state <= ST_WAIT;
                  cnt   <= '0;
               end
            end
            ST_WAIT: begin
               if (dmem_ack || timeout) state <= ST_IDLE;
               else                     cnt   <= cnt + CNT_W'(1);
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         RegWriteW   <= 1'b0;
         ResultSrcW  <= '0;
         RD_W        <= '0;
         ALU_ResultW <= '0;
         ReadDataW   <= '0;
         PCPlus4W    <= '0;
      end else begin
         RegWriteW   <= RegWriteM & ~StallM & ~MisalignM & ~BusErrM;
         ResultSrcW  <= ResultSrcM;
         RD_W        <= RD_M;
         ALU_ResultW <= ALU_ResultM;
         ReadDataW   <= rdata_ext;
         PCPlus4W    <= PCPlus4M;
      end
   end

endmodule

// File: tb/tb_mem_access_cycle.sv
// Directed bench for mem_access_cycle: expected writebacks are queued at issue
// time and compared when the instruction leaves the MEM stage.
module tb_mem_access_cycle;
   import mem_access_cycle_pkg::*;

   logic        clk, rst;
   logic        RegWriteM, MemWriteM;
   logic [1:0]  ResultSrcM;
   logic [2:0]  Funct3M;
   logic [4:0]  RD_M;
   logic [31:0] ALU_ResultM, WriteDataM, PCPlus4M;
   logic        dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic        RegWriteW;
   logic [1:0]  ResultSrcW;
   logic [4:0]  RD_W;
   logic [31:0] ALU_ResultW, ReadDataW, PCPlus4W;
   logic        StallM, MisalignM, BusErrM;

   typedef struct {
      logic        rw;
      logic [1:0]  rs;
      logic [4:0]  rd;
      logic [31:0] alu;
      logic [31:0] rdata;
      logic [31:0] pc;
   } wb_t;

   wb_t exp_q[$];
   int  checks = 0;
   int  errors = 0;

   mem_access_cycle #(.MAX_WAIT(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .RegWriteM   (RegWriteM),
      .MemWriteM   (MemWriteM),
      .ResultSrcM  (ResultSrcM),
      .Funct3M     (Funct3M),
      .RD_M        (RD_M),
      .ALU_ResultM (ALU_ResultM),
      .WriteDataM  (WriteDataM),
      .PCPlus4M    (PCPlus4M),
      .dmem_req    (dmem_req),
      .dmem_we     (dmem_we),
      .dmem_addr   (dmem_addr),
      .dmem_be     (dmem_be),
      .dmem_wdata  (dmem_wdata),
      .dmem_ack    (dmem_ack),
      .dmem_rdata  (dmem_rdata),
      .RegWriteW   (RegWriteW),
      .ResultSrcW  (ResultSrcW),
      .RD_W        (RD_W),
      .ALU_ResultW (ALU_ResultW),
      .ReadDataW   (ReadDataW),
      .PCPlus4W    (PCPlus4W),
      .StallM      (StallM),
      .MisalignM   (MisalignM),
      .BusErrM     (BusErrM)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic drive_nop();
      RegWriteM   = 1'b0;
      MemWriteM   = 1'b0;
      ResultSrcM  = RS_ALU;
      Funct3M     = F3_W;
      RD_M        = '0;
      ALU_ResultM = '0;
      WriteDataM  = '0;
      PCPlus4M    = '0;
      dmem_ack    = 1'b0;
      dmem_rdata  = '0;
   endtask

   // ack_after: cycle index (0 = issue cycle) on which dmem_ack is raised, -1 = never.
   task automatic do_access(
      input string tag, input logic we, input logic [1:0] rs, input logic [2:0] f3,
      input logic rw, input logic [4:0] rd, input logic [31:0] a, input logic [31:0] wd,
      input logic [31:0] pc, input logic [31:0] rdata, input int ack_after,
      input logic exp_req, input logic [3:0] exp_be, input logic [31:0] exp_wdata,
      input int exp_stalls, input logic exp_mis, input logic exp_berr,
      input logic exp_rw, input logic [31:0] exp_rdata);
      wb_t e, got;
      int  stalls;
      bit  done;
      stalls = 0;
      done   = 1'b0;
      @(negedge clk);
      RegWriteM = rw; MemWriteM = we; ResultSrcM = rs; Funct3M = f3; RD_M = rd;
      ALU_ResultM = a; WriteDataM = wd; PCPlus4M = pc;
      e.rw = exp_rw; e.rs = rs; e.rd = rd; e.alu = a; e.rdata = exp_rdata; e.pc = pc;
      exp_q.push_back(e);
      for (int c = 0; c < 40; c++) begin
         dmem_ack   = (c == ack_after);
         dmem_rdata = rdata;
         #1;
         if (c == 0) begin
            chk({tag, " misalign"}, 32'(MisalignM), 32'(exp_mis));
            if (exp_req) begin
               chk({tag, " we"}, 32'(dmem_we), 32'(we));
               chk({tag, " be"}, 32'(dmem_be), 32'(exp_be));
               if (we) chk({tag, " wdata"}, dmem_wdata, exp_wdata);
            end
         end
         if (StallM) begin
            stalls++;
            chk({tag, " req_held"}, 32'(dmem_req), 32'(1));
            if (exp_req) chk({tag, " addr_held"}, dmem_addr, {a[31:2], 2'b00});
         end else begin
            done = 1'b1;
            chk({tag, " buserr"}, 32'(BusErrM), 32'(exp_berr));
            chk({tag, " req_final"}, 32'(dmem_req), 32'(exp_req & ~exp_berr));
         end
         @(posedge clk);
         #1;
         dmem_ack = 1'b0;
         if (done) break;
         chk({tag, " bubble"}, 32'(RegWriteW), 32'(0));
         @(negedge clk);
      end
      if (!done) begin
         chk({tag, " completion_timeout"}, 32'(0), 32'(1));
      end else if (exp_q.size() == 0) begin
         chk({tag, " queue_empty"}, 32'(0), 32'(1));
      end else begin
         got = exp_q.pop_front();
         chk({tag, " stalls"}, 32'(stalls), 32'(exp_stalls));
         chk({tag, " RegWriteW"}, 32'(RegWriteW), 32'(got.rw));
         chk({tag, " ResultSrcW"}, 32'(ResultSrcW), 32'(got.rs));
         chk({tag, " RD_W"}, 32'(RD_W), 32'(got.rd));
         chk({tag, " ALU_ResultW"}, ALU_ResultW, got.alu);
         chk({tag, " PCPlus4W"}, PCPlus4W, got.pc);
         if (got.rs == RS_LOAD && got.rw) chk({tag, " ReadDataW"}, ReadDataW, got.rdata);
      end
   endtask

   initial begin
      rst = 1'b1;
      drive_nop();
      #2 rst = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst RegWriteW", 32'(RegWriteW), 32'(0));
      chk("rst ReadDataW", ReadDataW, 32'h0);
      chk("rst PCPlus4W", PCPlus4W, 32'h0);
      chk("rst dmem_req", 32'(dmem_req), 32'(0));
      chk("rst StallM", 32'(StallM), 32'(0));
      @(negedge clk);
      rst = 1'b1;

      //        tag    we  rs       f3     rw rd  a             wd            pc          rdata         ack req be       wdata         st mis berr rw exp_rdata
      do_access("sw",  1, RS_ALU,  F3_W,  0, 0,  32'h100,      32'hDEADBEEF, 32'h1004,   32'h0,        0,  1, 4'b1111, 32'hDEADBEEF, 0, 0, 0,   0, 32'h0);
      do_access("lb",  0, RS_LOAD, F3_B,  1, 5,  32'h203,      32'h0,        32'h1008,   32'h80FF1234, 3,  1, 4'b1111, 32'h0,        3, 0, 0,   1, 32'hFFFFFF80);
      do_access("lhu", 0, RS_LOAD, F3_HU, 1, 6,  32'h202,      32'h0,        32'h100C,   32'h80FF1234, 0,  1, 4'b1111, 32'h0,        0, 0, 0,   1, 32'h000080FF);
      do_access("sb",  1, RS_ALU,  F3_B,  0, 0,  32'h1,        32'hAB,       32'h1010,   32'h0,        0,  1, 4'b0010, 32'hABABABAB, 0, 0, 0,   0, 32'h0);
      do_access("sh",  1, RS_ALU,  F3_H,  0, 0,  32'h2,        32'h1234CDEF, 32'h1014,   32'h0,        2,  1, 4'b1100, 32'hCDEFCDEF, 2, 0, 0,   0, 32'h0);
      do_access("lh",  0, RS_LOAD, F3_H,  1, 7,  32'h200,      32'h0,        32'h1018,   32'h00008001, 1,  1, 4'b1111, 32'h0,        1, 0, 0,   1, 32'hFFFF8001);
      do_access("lbu", 0, RS_LOAD, F3_BU, 1, 8,  32'h201,      32'h0,        32'h101C,   32'h80FF1234, 0,  1, 4'b1111, 32'h0,        0, 0, 0,   1, 32'h00000012);
      do_access("lw_mis", 0, RS_LOAD, F3_W, 1, 9, 32'h102,     32'h0,        32'h1020,   32'h0,        -1, 0, 4'b1111, 32'h0,        0, 1, 0,   0, 32'h0);
      do_access("sh_mis", 1, RS_ALU, F3_H, 0, 0, 32'h3,        32'h5555,     32'h1024,   32'h0,        -1, 0, 4'b1111, 32'h0,        0, 1, 0,   0, 32'h0);
      // ALU pass-through with a stray ack while no request is outstanding
      do_access("alu", 0, RS_ALU,  F3_W,  1, 10, 32'h102,      32'h0,        32'h1028,   32'h0,        0,  0, 4'b1111, 32'h0,        0, 0, 0,   1, 32'h0);
      do_access("pc4", 0, RS_PC4,  F3_B,  1, 1,  32'h7,        32'h0,        32'h2000,   32'h0,        0,  0, 4'b1111, 32'h0,        0, 0, 0,   1, 32'h0);
      do_access("lw_to", 0, RS_LOAD, F3_W, 1, 12, 32'h500,     32'h0,        32'h102C,   32'h0,        -1, 1, 4'b1111, 32'h0,       16, 0, 1,   0, 32'h0);
      do_access("lw",  0, RS_LOAD, F3_W,  1, 11, 32'h300,      32'h0,        32'h1030,   32'hCAFEF00D, 0,  1, 4'b1111, 32'h0,        0, 0, 0,   1, 32'hCAFEF00D);

      // Reset asserted while an access sits in WAIT
      @(negedge clk);
      RegWriteM = 1'b1; MemWriteM = 1'b0; ResultSrcM = RS_LOAD; Funct3M = F3_W;
      RD_M = 5'd13; ALU_ResultM = 32'h400; PCPlus4M = 32'h1034; dmem_ack = 1'b0;
      #1;
      chk("rstw req_before", 32'(dmem_req), 32'(1));
      repeat (3) @(posedge clk);
      @(negedge clk);
      #2 rst = 1'b0;
      #1;
      chk("rstw dmem_req", 32'(dmem_req), 32'(0));
      chk("rstw StallM", 32'(StallM), 32'(0));
      chk("rstw BusErrM", 32'(BusErrM), 32'(0));
      chk("rstw MisalignM", 32'(MisalignM), 32'(0));
      chk("rstw RD_W", 32'(RD_W), 32'(0));
      chk("rstw ALU_ResultW", ALU_ResultW, 32'h0);
      chk("rstw ReadDataW", ReadDataW, 32'h0);
      drive_nop();
      @(negedge clk);
      rst = 1'b1;
      do_access("post_rst", 0, RS_LOAD, F3_W, 1, 14, 32'h600, 32'h0, 32'h1038, 32'h01020304, 1, 1, 4'b1111, 32'h0, 1, 0, 0, 1, 32'h01020304);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
